// File: rtl/seg_pkg.sv
// Shared glyph/code constants, the glyph decoder and the scan FSM state type
// for the seven-segment scan bus receiver.
package seg_pkg;

    // Segment bit order {g,f,e,d,c,b,a}; the decimal point is never decoded.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } scan_state_e;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            SEG_0:     return 4'h0;
            SEG_1:     return 4'h1;
            SEG_2:     return 4'h2;
            SEG_3:     return 4'h3;
            SEG_4:     return 4'h4;
            SEG_5:     return 4'h5;
            SEG_6:     return 4'h6;
            SEG_7:     return 4'h7;
            SEG_8:     return 4'h8;
            SEG_9:     return 4'h9;
            SEG_E:     return CODE_E;
            SEG_BLANK: return CODE_BLANK;
            default:   return CODE_BAD;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop vector synchronizer, asynchronous active-high reset to zero.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 4-digit seven-segment scan bus: settles each
// scanned glyph, decodes it and assembles complete 4-digit frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE         = 1000,
    parameter int unsigned TIMEOUT        = 2_000_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          ENA_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  ena,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        scan_err,
    output logic        stale
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
    localparam logic [15:0]   DIGITS_RST  = {4{CODE_BLANK}};

    logic [11:0] raw_in;
    logic [11:0] pair_s;
    logic [3:0]  ena_s;
    logic [7:0]  seg_s;

    assign raw_in = {ena ^ {4{ENA_ACTIVE_LOW}}, seg ^ {8{SEG_ACTIVE_LOW}}};

    sync2 #(.W(12)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (raw_in),
        .q_o (pair_s)
    );

    assign ena_s = pair_s[11:8];
    assign seg_s = pair_s[7:0];

    scan_state_e state_q, state_d;
    logic [11:0] pair_q;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] digits_q, digits_d;
    logic        fv_q, fv_d;
    logic        ferr_q, ferr_d;
    logic        serr_q, serr_d;
    logic        multi_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic        stale_q, stale_d;

    logic        onehot;
    logic        multi;
    logic        changed;
    logic        accept;
    logic        frame;
    logic [3:0]  code;
    logic [3:0]  mask_new;

    always_comb begin
        multi   = (ena_s & (ena_s - 4'd1)) != 4'd0;
        onehot  = (ena_s != 4'd0) && !multi;
        changed = pair_s != pair_q;
        code    = seg_decode(seg_s[6:0]);
    end

    // Any change of the synced pair restarts settling, whatever the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!onehot) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (changed || state_q == S_IDLE) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
        end else if (state_q == S_SETTLE) begin
            if (cnt_q == SETTLE_LAST) begin
                accept  = 1'b1;
                state_d = S_HOLD;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end
    end

    always_comb begin
        mask_d   = mask_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        fv_d     = 1'b0;
        ferr_d   = ferr_q;
        frame    = 1'b0;
        mask_new = mask_q | ena_s;
        if (accept) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ena_s[i]) begin
                    shadow_d[i*4 +: 4] = code;
                end
            end
            if (mask_new == 4'hF) begin
                frame    = 1'b1;
                fv_d     = 1'b1;
                digits_d = shadow_d;
                mask_d   = '0;
                ferr_d   = 1'b0;
                for (int unsigned i = 0; i < 4; i++) begin
                    if (shadow_d[i*4 +: 4] == CODE_BAD) begin
                        ferr_d = 1'b1;
                    end
                end
            end else begin
                mask_d = mask_new;
            end
        end
    end

    // A frame on the timeout cycle clears the count, so stale never rises then.
    always_comb begin
        serr_d = multi && !multi_q;
        if (frame) begin
            tcnt_d = '0;
        end else if (tcnt_q == TIMEOUT_MAX) begin
            tcnt_d = tcnt_q;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
        stale_d = tcnt_d == TIMEOUT_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pair_q   <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= DIGITS_RST;
            digits_q <= DIGITS_RST;
            fv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            serr_q   <= 1'b0;
            multi_q  <= 1'b0;
            tcnt_q   <= '0;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pair_q   <= pair_s;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            fv_q     <= fv_d;
            ferr_q   <= ferr_d;
            serr_q   <= serr_d;
            multi_q  <= multi;
            tcnt_q   <= tcnt_d;
            stale_q  <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign scan_err    = serr_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder with SETTLE=4, TIMEOUT=200.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 200;

    // Glyphs {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] G1 = 8'h06, G2 = 8'h5B, G3 = 8'h4F, G4 = 8'h66,
                           G5 = 8'h6D, G6 = 8'h7D, G7 = 8'h07, G8 = 8'h7F,
                           G9 = 8'h6F, G0 = 8'h3F, GE = 8'h79, GBAD = 8'h49;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  ena;
    logic [15:0] digits;
    logic        frame_valid, frame_err, scan_err, stale;

    seg_scan_decoder #(
        .SETTLE(SETTLE),
        .TIMEOUT(TIMEOUT),
        .SEG_ACTIVE_LOW(1'b0),
        .ENA_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg(seg),
        .ena(ena),
        .digits(digits),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .scan_err(scan_err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic        err;
        int          at;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int errors = 0;
    int checks = 0;
    int scan_pulses = 0;
    int last_frame = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (scan_err) scan_pulses++;
            if (frame_valid) begin
                last_frame = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got digits %h at cycle %0d, expected none", digits, cyc);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("frame_digits", 32'(digits), 32'(mon_f.d));
                    check("frame_err", 32'(frame_err), 32'(mon_f.err));
                    check("frame_cycle", cyc, mon_f.at);
                    check("frame_stale", 32'(stale), 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] e, input logic [7:0] s, input int hold);
        @(negedge clk);
        ena = e;
        seg = s;
        repeat (hold - 1) @(negedge clk);
    endtask

    // Final digit of a frame: the frame lands 7 edges after this negedge.
    task automatic last_digit(input logic [3:0] e, input logic [7:0] s,
                              input logic [15:0] d, input logic err);
        frame_t f;
        @(negedge clk);
        ena = e;
        seg = s;
        f.d = d;
        f.err = err;
        f.at = cyc + 7;
        exp_q.push_back(f);
        repeat (19) @(negedge clk);
    endtask

    task automatic wait_frames();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("frame_arrived", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0000BBBB);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_scan_err"}, 32'(scan_err), 32'd0);
        check({tag, "_stale"}, 32'(stale), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int base;
        int f2;
        int f3;
        rst = 1'b1;
        ena = 4'd0;
        seg = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Plain frame 4321
        drive(4'b0001, G1, 20);
        drive(4'b0010, G2, 20);
        drive(4'b0100, G3, 20);
        last_digit(4'b1000, G4, 16'h4321, 1'b0);
        wait_frames();
        drive(4'b0000, 8'h00, 10);

        // Digit1 toggles faster than SETTLE, then holds
        drive(4'b0001, G9, 20);
        drive(4'b0100, G0, 20);
        drive(4'b1000, GE, 20);
        for (int i = 0; i < 8; i++) drive(4'b0010, (i % 2 == 1) ? G6 : G5, 3);
        last_digit(4'b0010, G7, 16'hA079, 1'b0);
        wait_frames();

        // Multi-hot bursts keep the partial mask
        drive(4'b0001, G2, 20);
        drive(4'b0010, G3, 20);
        base = scan_pulses;
        drive(4'b0101, G8, 5);
        drive(4'b0110, G8, 5);
        drive(4'b0000, 8'h00, 4);
        check("scan_err_once", scan_pulses - base, 1);
        drive(4'b0011, G8, 6);
        drive(4'b0000, 8'h00, 4);
        check("scan_err_again", scan_pulses - base, 2);
        drive(4'b0100, G4, 20);
        last_digit(4'b1000, G5, 16'h5432, 1'b0);
        wait_frames();

        // Invalid glyph on digit2 (dp set on digit0 must be ignored), then clean
        drive(4'b0001, 8'h86, 20);
        drive(4'b0010, G1, 20);
        drive(4'b0100, GBAD, 20);
        last_digit(4'b1000, G1, 16'h1F11, 1'b1);
        wait_frames();
        drive(4'b0001, 8'hFD, 20);
        drive(4'b0010, G7, 20);
        drive(4'b0100, G8, 20);
        last_digit(4'b1000, G9, 16'h9876, 1'b0);
        wait_frames();

        // Timeout
        drive(4'b0000, 8'h00, 1);
        while (cyc < last_frame + 190) @(negedge clk);
        check("stale_early", 32'(stale), 32'd0);
        while (cyc < last_frame + 205) @(negedge clk);
        check("stale_set", 32'(stale), 32'd1);

        drive(4'b0001, G1, 20);
        drive(4'b0010, G2, 20);
        drive(4'b0100, G3, 20);
        last_digit(4'b1000, G4, 16'h4321, 1'b0);
        wait_frames();
        f2 = last_frame;
        drive(4'b0001, G1, 20);
        drive(4'b0010, G2, 20);
        drive(4'b0100, G3, 20);
        while (cyc < f2 + 192) @(negedge clk);
        check("stale_before_coincide", 32'(stale), 32'd0);
        last_digit(4'b1000, GBAD, 16'hF321, 1'b1);
        wait_frames();
        f3 = last_frame;

        // Reset mid-frame
        drive(4'b0001, G1, 20);
        drive(4'b0010, G2, 20);
        drive(4'b0000, 8'h00, 1);
        while (cyc < f3 + 205) @(negedge clk);
        check("stale_before_reset", 32'(stale), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0100, G7, 20);
        drive(4'b1000, G8, 20);
        drive(4'b0001, G5, 20);
        last_digit(4'b0010, G6, 16'h8765, 1'b0);
        wait_frames();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
